// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the VGA text framebuffer writer.
package fb_pkg;

    localparam int FB_COLS          = 80;
    localparam int FB_ROWS          = 30;
    localparam int FB_CELLS_DEFAULT = 2400;

    // Command codes accepted on the request port.
    typedef enum logic [1:0] {
        CMD_WRITE  = 2'd0,
        CMD_PUTC   = 2'd1,
        CMD_SETCUR = 2'd2,
        CMD_CLEAR  = 2'd3
    } fb_cmd_t;

    // Writer FSM states; ST_CLEAR exists only when clearing is built in.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    // True when a cell address lies inside the visible framebuffer.
    function automatic logic addr_valid(input logic [31:0] addr, input int unsigned cells);
        return addr < cells;
    endfunction

endpackage

// File: rtl/fb_cmd_fifo.sv
// fb_cmd_fifo: synchronous command FIFO (DEPTH must be a power of two, >= 2).
// Push and pop may happen in the same cycle when neither full nor empty.
module fb_cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write; entries are only ever read after being written.
    // NOTE: the storage array has no reset -- validity is tracked by the
    // pointers and count, so resetting the data would only add muxes.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: command-driven write master for the VGA text framebuffer.
// Optional feature macro: FB_WRITER_CLEAR_EN -- when defined, CMD_CLEAR fills
// every cell and homes the cursor; when undefined, CMD_CLEAR is a no-op and the
// CLEAR state and its counter are not built.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FB_ADDR_W  = 12,
    parameter int FB_DATA_W  = 8,
    parameter int FB_CELLS   = FB_CELLS_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_cmd,
    input  logic [FB_ADDR_W-1:0] req_addr,
    input  logic [FB_DATA_W-1:0] req_data,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [FB_DATA_W-1:0] fb_data,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] cursor,
    output logic                 busy
);

    localparam int ENTRY_W = 2 + FB_ADDR_W + FB_DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FB_ADDR_W-1:0] LAST_CELL = FB_ADDR_W'(FB_CELLS - 1);
    localparam logic [FB_ADDR_W-1:0] ADDR_ONE  = FB_ADDR_W'(1);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [ENTRY_W-1:0]   head_entry;
    logic                 push;
    logic                 pop;
    fb_cmd_t              head_cmd;
    logic [FB_ADDR_W-1:0] head_addr;
    logic [FB_DATA_W-1:0] head_data;

    logic                 fb_we_q;
    logic [FB_ADDR_W-1:0] fb_addr_q;
    logic [FB_DATA_W-1:0] fb_data_q;
    logic [FB_ADDR_W-1:0] cursor_q;
    logic                 busy_q;
    logic                 idle;

`ifdef FB_WRITER_CLEAR_EN
    fb_state_t            state_q;
    logic [FB_ADDR_W-1:0] clr_cnt_q;
    assign idle = (state_q == ST_IDLE);
`else
    assign idle = 1'b1;
`endif

    // Full is judged on the registered count only, so a pop never opens ready
    // in the same cycle (no push-through).
    assign req_ready = !rst && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = idle && !fifo_empty;

    assign head_cmd  = fb_cmd_t'(head_entry[ENTRY_W-1 -: 2]);
    assign head_addr = head_entry[FB_DATA_W +: FB_ADDR_W];
    assign head_data = head_entry[FB_DATA_W-1:0];

    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign cursor  = cursor_q;
    assign busy    = busy_q;

    fb_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk50),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i ({req_cmd, req_addr, req_data}),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Command FSM: executes the FIFO head, sweeps the clear, drives the
    // registered write port, cursor and busy flag.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            cursor_q  <= '0;
            busy_q    <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
`endif
        end else begin
            fb_we_q <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
            busy_q  <= (fifo_count != '0) || (state_q != ST_IDLE);
`else
            busy_q  <= (fifo_count != '0);
`endif

            if (pop) begin
                case (head_cmd)
                    CMD_WRITE: begin
                        if (addr_valid(32'(head_addr), FB_CELLS)) begin
                            fb_we_q   <= 1'b1;
                            fb_addr_q <= head_addr;
                            fb_data_q <= head_data;
                        end
                    end
                    CMD_PUTC: begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= cursor_q;
                        fb_data_q <= head_data;
                        cursor_q  <= (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_ONE;
                    end
                    CMD_SETCUR: begin
                        cursor_q <= addr_valid(32'(head_addr), FB_CELLS) ? head_addr : '0;
                    end
                    CMD_CLEAR: begin
`ifdef FB_WRITER_CLEAR_EN
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= '0;
                        fb_data_q <= head_data;
                        if (FB_CELLS == 1) begin
                            cursor_q <= '0;
                        end else begin
                            state_q   <= ST_CLEAR;
                            clr_cnt_q <= ADDR_ONE;
                        end
`endif
                    end
                endcase
            end

`ifdef FB_WRITER_CLEAR_EN
            // Clear sweep: fb_data_q keeps the fill byte latched at the pop.
            if (state_q == ST_CLEAR) begin
                fb_we_q   <= 1'b1;
                fb_addr_q <= clr_cnt_q;
                if (clr_cnt_q == LAST_CELL) begin
                    state_q  <= ST_IDLE;
                    cursor_q <= '0;
                end else begin
                    clr_cnt_q <= clr_cnt_q + ADDR_ONE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: scoreboard bench for fb_writer. Stimulus pushes expected
// framebuffer writes into a queue; a negedge monitor pops and compares every
// strobe. Builds with or without FB_WRITER_CLEAR_EN.
module tb_fb_writer;
    import fb_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int CELLS = 2400;
    localparam int DEPTH = 8;

    logic          clk50 = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cmd;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          fb_we;
    logic [AW-1:0] cursor;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;
    logic [AW-1:0]    m_cur;

    fb_writer #(
        .FB_ADDR_W  (AW),
        .FB_DATA_W  (DW),
        .FB_CELLS   (CELLS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50     (clk50),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .cursor    (cursor),
        .busy      (busy)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endfunction

    // Behavioural reference used for the random phase.
    function automatic void model(input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (cmd)
            2'd0: if (int'(a) < CELLS) exp_write(a, d);
            2'd1: begin
                exp_write(m_cur, d);
                m_cur = (int'(m_cur) == CELLS - 1) ? '0 : m_cur + AW'(1);
            end
            2'd2: m_cur = (int'(a) < CELLS) ? a : '0;
            default: begin
`ifdef FB_WRITER_CLEAR_EN
                for (int i = 0; i < CELLS; i++) exp_write(AW'(i), d);
                m_cur = '0;
`endif
            end
        endcase
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk50) begin
        if (!rst && fb_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(fb_we), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe_addr_data", 32'({fb_addr, fb_data}), 32'(mon_exp));
            end
        end
    end

    // Offer one command (called at a negedge); returns at the negedge after acceptance.
    task automatic send(input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waited);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = a;
        req_data  = d;
        waited    = 0;
        while (!req_ready && waited < 10000) begin
            @(negedge clk50);
            waited++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        else @(posedge clk50);
        @(negedge clk50);
        req_valid = 1'b0;
    endtask

    // Wait until the writer is quiet, then require the scoreboard to be drained.
    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk50);
        while (busy && n < 8000) begin
            @(negedge clk50);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n_clear;
        logic [1:0]    rc;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0;
        repeat (3) @(negedge clk50);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk50);

        // Single WRITE: one strobe, one cycle after acceptance.
        exp_write(12'h005, 8'h41);
        send(CMD_WRITE, 12'h005, 8'h41, w);
        check("t1_no_we_at_accept", 32'(fb_we), 32'd0);
        @(negedge clk50);
        check("t1_we", 32'(fb_we), 32'd1);
        check("t1_busy_during", 32'(busy), 32'd1);
        @(negedge clk50);
        check("t1_we_single", 32'(fb_we), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Cursor wrap: 2398, 2399, 0 on consecutive cycles.
        send(CMD_SETCUR, 12'd2398, 8'h00, w);
        exp_write(12'd2398, 8'h58); send(CMD_PUTC, 12'h000, 8'h58, w);
        exp_write(12'd2399, 8'h59); send(CMD_PUTC, 12'h000, 8'h59, w);
        exp_write(12'd0,    8'h5A); send(CMD_PUTC, 12'h000, 8'h5A, w);
        check("t2_y_we", 32'(fb_we), 32'd1);
        check("t2_y_addr", 32'(fb_addr), 32'd2399);
        @(negedge clk50);
        check("t2_z_we", 32'(fb_we), 32'd1);
        check("t2_z_addr", 32'(fb_addr), 32'd0);
        wait_idle();
        check("t2_cursor", 32'(cursor), 32'd1);

        // Out-of-range WRITE and SETCUR: no strobe, cursor homed.
        send(CMD_WRITE, 12'd2400, 8'h55, w);
        send(CMD_SETCUR, 12'd4000, 8'h00, w);
        wait_idle();
        check("t3_cursor", 32'(cursor), 32'd0);

        // CLEAR followed by 9 WRITEs; FIFO fills behind the clear.
        send(CMD_SETCUR, 12'd100, 8'h00, w);
`ifdef FB_WRITER_CLEAR_EN
        for (int i = 0; i < CELLS; i++) exp_write(AW'(i), 8'h20);
`endif
        send(CMD_CLEAR, 12'h000, 8'h20, w);
        for (int k = 1; k <= 8; k++) begin
            exp_write(AW'(k * 7 + 3), DW'(8'h60 + k));
            send(CMD_WRITE, AW'(k * 7 + 3), DW'(8'h60 + k), w);
        end
`ifdef FB_WRITER_CLEAR_EN
        check("t4_ready_low_when_full", 32'(req_ready), 32'd0);
`else
        check("t4_ready_high_no_clear", 32'(req_ready), 32'd1);
`endif
        exp_write(12'd2000, 8'h69);
        send(CMD_WRITE, 12'd2000, 8'h69, w);
`ifdef FB_WRITER_CLEAR_EN
        check("t4_ready_low_cycles", 32'(w), 32'd2393);
`else
        check("t4_ready_low_cycles", 32'(w), 32'd0);
`endif
        wait_idle();
`ifdef FB_WRITER_CLEAR_EN
        check("t4_cursor", 32'(cursor), 32'd0);
`else
        check("t4_cursor", 32'(cursor), 32'd100);
`endif

        // Reset in the middle of a CLEAR.
        send(CMD_SETCUR, 12'd7, 8'h00, w);
`ifdef FB_WRITER_CLEAR_EN
        for (int i = 0; i < CELLS; i++) exp_write(AW'(i), 8'h2E);
`endif
        send(CMD_CLEAR, 12'h000, 8'h2E, w);
        repeat (50) @(negedge clk50);
        #2 rst = 1'b1;
        #1;
        check("t5_we_dropped", 32'(fb_we), 32'd0);
        check("t5_cursor", 32'(cursor), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        @(negedge clk50);
        rst = 1'b0;
        repeat (3) @(negedge clk50);
        check("t5_fifo_empty", 32'(busy), 32'd0);
        exp_write(12'h123, 8'h7E);
        send(CMD_WRITE, 12'h123, 8'h7E, w);
        check("t5_no_we_at_accept", 32'(fb_we), 32'd0);
        @(negedge clk50);
        check("t5_we_latency", 32'(fb_we), 32'd1);
        wait_idle();

        // Random commands with req_valid held high.
        m_cur   = '0;
        n_clear = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 199) == 0 && n_clear < 2) begin
                rc = 2'd3;
                n_clear++;
            end else begin
                rc = 2'($urandom_range(0, 2));
            end
            ra = AW'($urandom_range(0, 2599));
            rd = DW'($urandom);
            model(rc, ra, rd);
            send(rc, ra, rd, w);
        end
        wait_idle();
        check("t6_cursor", 32'(cursor), 32'(m_cur));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
